sum_accumulator: RTL

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sum_accumulator.sv
// Handshaked accumulator: sums `len` operands and reports the sum plus sticky carry/overflow flags.
// Define SUM_ACC_SAT_EN to clamp the accumulator on signed overflow instead of wrapping.
module sum_accumulator #(
    parameter int N     = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_cout_any,
    output logic             out_ovf_any,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    state_t           state, state_d;
    logic [N-1:0]     acc, acc_d;
    logic [CNT_W-1:0] remaining, remaining_d;
    logic             cout_any, cout_any_d;
    logic             ovf_any, ovf_any_d;

    logic             accept;
    logic [N:0]       sum_ext;
    logic [N-1:0]     sum_raw;
    logic             add_carry;
    logic             add_ovf;
    logic [N-1:0]     add_result;

    assign accept    = (state == ACCUM) && in_valid;
    assign sum_ext   = {1'b0, acc} + {1'b0, in_data};
    assign sum_raw   = sum_ext[N-1:0];
    assign add_carry = sum_ext[N];
    // Like-signed operands whose result sign differs from them is a signed overflow.
    assign add_ovf   = (acc[N-1] == in_data[N-1]) && (sum_raw[N-1] != acc[N-1]);

`ifdef SUM_ACC_SAT_EN
    // Both operands share a sign on overflow, so acc's sign picks the rail.
    assign add_result = add_ovf ? (acc[N-1] ? SAT_MIN : SAT_MAX) : sum_raw;
`else
    assign add_result = sum_raw;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state;
        acc_d       = acc;
        remaining_d = remaining;
        cout_any_d  = cout_any;
        ovf_any_d   = ovf_any;

        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    cout_any_d  = 1'b0;
                    ovf_any_d   = 1'b0;
                    remaining_d = len;
                    state_d     = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d       = add_result;
                    cout_any_d  = cout_any | add_carry;
                    ovf_any_d   = ovf_any | add_ovf;
                    remaining_d = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all state, and the async reset clears every register so an abandoned run leaves nothing behind.
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            cout_any  <= 1'b0;
            ovf_any   <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            remaining <= remaining_d;
            cout_any  <= cout_any_d;
            ovf_any   <= ovf_any_d;
        end
    end

    // All outputs decode or forward registers only.
    assign in_ready     = (state == ACCUM);
    assign out_valid    = (state == DONE);
    assign busy         = (state != IDLE);
    assign out_sum      = acc;
    assign out_cout_any = cout_any;
    assign out_ovf_any  = ovf_any;

endmodule
